// File: rtl/conv1d_ctrl_pkg.sv
// Shared types and defaults for the conv1d run sequencer.
package conv1d_ctrl_pkg;

  localparam int unsigned LEN_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    MAC    = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } conv1d_ctrl_state_e;

endpackage

// File: rtl/conv1d_ctrl_fsm.sv
// Sequencer for one conv1d run: start edge -> per-output CLEAR/MAC/WRITE loop -> FINISH.
// Handshake: out_valid_o stays high with out_idx_o stable until a cycle with out_ready_i high.
module conv1d_ctrl_fsm
  import conv1d_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] in_len_i,
  input  logic [LEN_W-1:0] k_len_i,
  output logic             mac_clr_o,
  output logic             mac_en_o,
  output logic [LEN_W-1:0] in_idx_o,
  output logic [LEN_W-1:0] k_idx_o,
  output logic [LEN_W-1:0] out_idx_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             running_o,
  output logic             running_e_o,
  output logic             done_o,
  output logic             done_e_o,
  output logic             err_o,
  output logic [2:0]       state_o
);

  conv1d_ctrl_state_e state_q, state_d;

  logic             start_q;
  logic [LEN_W-1:0] k_q;
  logic [LEN_W-1:0] out_idx_q;
  logic [LEN_W-1:0] k_last_q;
  logic [LEN_W-1:0] m_last_q;
  logic             err_q;
  logic             launch;
  logic             lens_ok;

  // Launch is suppressed while reset is asserted so no strobe escapes a reset cycle.
  assign launch  = start_i & ~start_q & ~rst_i & (state_q == IDLE);
  assign lens_ok = (k_len_i != '0) && (k_len_i <= in_len_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = lens_ok ? CLEAR : FINISH;
      CLEAR:   state_d = MAC;
      MAC:     if (k_q == k_last_q) state_d = WRITE;
      WRITE:   if (out_ready_i) state_d = (out_idx_q == m_last_q) ? FINISH : CLEAR;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start_q resets high so a start level held through reset is not seen as an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q   <= 1'b1;
      k_q       <= '0;
      out_idx_q <= '0;
      k_last_q  <= '0;
      m_last_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      start_q <= start_i;
      case (state_q)
        IDLE: begin
          if (launch) begin
            out_idx_q <= '0;
            if (lens_ok) begin
              k_last_q <= k_len_i - LEN_W'(1);
              m_last_q <= in_len_i - k_len_i;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CLEAR: k_q <= '0;
        MAC:   k_q <= k_q + LEN_W'(1);
        WRITE: if (out_ready_i && (out_idx_q != m_last_q)) out_idx_q <= out_idx_q + LEN_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    mac_clr_o   = 1'b0;
    mac_en_o    = 1'b0;
    in_idx_o    = '0;
    k_idx_o     = '0;
    out_valid_o = 1'b0;
    running_o   = 1'b0;
    running_e_o = 1'b0;
    done_o      = 1'b0;
    done_e_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          running_o   = 1'b1;
          running_e_o = 1'b1;
          done_e_o    = 1'b1;
        end
      end
      CLEAR: mac_clr_o = 1'b1;
      MAC: begin
        mac_en_o = 1'b1;
        k_idx_o  = k_q;
        in_idx_o = out_idx_q + k_q;
      end
      WRITE: out_valid_o = 1'b1;
      FINISH: begin
        running_e_o = 1'b1;
        done_o      = 1'b1;
        done_e_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_idx_o = out_idx_q;
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_conv1d_ctrl_fsm.sv
// Scoreboard bench for conv1d_ctrl_fsm: expected MAC addresses, outputs and strobes are queued per run.
module tb_conv1d_ctrl_fsm;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [LEN_W-1:0] in_len_i = '0;
  logic [LEN_W-1:0] k_len_i = '0;
  logic             mac_clr_o, mac_en_o, out_valid_o;
  logic [LEN_W-1:0] in_idx_o, k_idx_o, out_idx_o;
  logic             out_ready_i = 1'b1;
  logic             running_o, running_e_o, done_o, done_e_o, err_o;
  logic [2:0]       state_o;

  conv1d_ctrl_fsm #(.LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .in_len_i(in_len_i), .k_len_i(k_len_i),
    .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o),
    .in_idx_o(in_idx_o), .k_idx_o(k_idx_o), .out_idx_o(out_idx_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .running_o(running_o), .running_e_o(running_e_o),
    .done_o(done_o), .done_e_o(done_e_o), .err_o(err_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // scoreboard state
  logic [31:0]      mac_q[$];
  logic [LEN_W-1:0] exp_q[$];
  logic             run_q[$];
  logic             done_q[$];

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  evt_cnt = 0;
  int  first_clr = -1;
  int  launch_cyc = -1;
  int  fin_cyc = -1;
  bit  fin_seen = 1'b0;
  bit  mon_en = 1'b0;
  int  bp_idx = 0;
  int  bp_left = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // back-pressure: hold ready low for bp_left cycles on output bp_idx
  always @(posedge clk) begin
    #2;
    if (out_valid_o && (int'(out_idx_o) == bp_idx) && bp_left > 0) begin
      out_ready_i = 1'b0;
      bp_left--;
    end else begin
      out_ready_i = 1'b1;
    end
  end

  // monitor
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (mac_en_o) begin
        if (mac_q.size() == 0) check("mac_unexpected", mac_en_o, 0);
        else check("mac_addr", {in_idx_o, k_idx_o}, mac_q.pop_front());
      end else begin
        check("idx_outside_mac", {in_idx_o, k_idx_o}, 0);
      end
      if (mac_clr_o && first_clr < 0) first_clr = cyc;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check("out_unexpected", out_valid_o, 0);
        else check("out_idx", out_idx_o, exp_q.pop_front());
      end
      if (running_e_o) begin
        evt_cnt++;
        if (run_q.size() == 0) check("running_e_unexpected", running_e_o, 0);
        else check("running_data", running_o, run_q.pop_front());
        if (running_o) launch_cyc = cyc;
      end
      if (done_e_o) begin
        evt_cnt++;
        if (done_q.size() == 0) check("done_e_unexpected", done_e_o, 0);
        else check("done_data", done_o, done_q.pop_front());
        if (done_o) begin
          fin_cyc  = cyc;
          fin_seen = 1'b1;
        end
      end
    end
  end

  // reference model: valid convolution over M = N-K+1 outputs, K taps each
  task automatic push_expect(input int n, input int k, input bit legal);
    if (legal) begin
      for (int o = 0; o < n - k + 1; o++) begin
        for (int j = 0; j < k; j++) mac_q.push_back({16'(o + j), 16'(j)});
        exp_q.push_back(LEN_W'(o));
      end
    end
    run_q.push_back(1'b1);
    run_q.push_back(1'b0);
    done_q.push_back(1'b0);
    done_q.push_back(1'b1);
  endtask

  task automatic check_idle_zero(input string name);
    check(name, {mac_clr_o, mac_en_o, in_idx_o, k_idx_o, out_idx_o, out_valid_o,
                 running_o, running_e_o, done_o, done_e_o, err_o}, 0);
  endtask

  task automatic run_one(input int n, input int k, input int bpi, input int bpc, input bit toggle);
    bit legal;
    int m;
    int stall;
    int budget;
    legal = (k >= 1) && (k <= n);
    m = legal ? n - k + 1 : 0;
    in_len_i = LEN_W'(n);
    k_len_i  = LEN_W'(k);
    push_expect(n, k, legal);
    bp_idx = bpi;
    stall = (legal && bpi < m) ? bpc : 0;
    bp_left = stall;
    fin_seen = 1'b0;
    first_clr = -1;
    launch_cyc = -1;
    fin_cyc = -1;
    @(posedge clk); #1 start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_i = 1'b0;
    if (toggle) begin
      repeat (2) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
    end
    budget = 2000;
    while (!fin_seen && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("run_done", fin_seen, 1);
    if (fin_seen) begin
      if (legal) begin
        check("clr_latency", first_clr - launch_cyc, 1);
        check("run_length", fin_cyc - first_clr, m * (k + 2) + stall);
      end else begin
        check("err_done_latency", fin_cyc - launch_cyc, 1);
        check("err_no_mac", first_clr, -1);
      end
    end
    check("err_flag", err_o, !legal);
    check("queues_empty", mac_q.size() + exp_q.size() + run_q.size() + done_q.size(), 0);
  endtask

  task automatic reset_mid_run();
    bit hit;
    int budget;
    int evt0;
    in_len_i = 16'd10;
    k_len_i  = 16'd3;
    push_expect(10, 3, 1'b1);
    bp_left = 0;
    fin_seen = 1'b0;
    hit = 1'b0;
    @(posedge clk); #1 start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_i = 1'b0;
    budget = 200;
    while (!hit && budget > 0) begin
      @(negedge clk); #1;
      if (mac_en_o && (in_idx_o - k_idx_o) == 16'd3) hit = 1'b1;
      budget--;
    end
    check("rst_trigger_reached", hit, 1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    mac_q.delete();
    exp_q.delete();
    run_q.delete();
    done_q.delete();
    @(negedge clk); #1;
    check_idle_zero("outputs_after_midrun_reset");
    evt0 = evt_cnt;
    repeat (20) @(negedge clk);
    #1;
    check("no_strobe_after_reset", evt_cnt - evt0, 0);
    check("no_done_after_reset", fin_seen, 0);
  endtask

  // stimulus
  initial begin
    int evt0;
    rst_i = 1'b1;
    start_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_idle_zero("reset_outputs");
    mon_en = 1'b1;
    evt0 = evt_cnt;
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("start_held_through_reset", evt_cnt - evt0, 0);
    @(posedge clk); #1 start_i = 1'b0;

    run_one(8, 3, 99, 0, 1'b1);
    run_one(4, 4, 99, 0, 1'b0);
    run_one(5, 1, 99, 0, 1'b0);
    run_one(5, 0, 99, 0, 1'b0);
    run_one(5, 6, 99, 0, 1'b0);
    run_one(6, 2, 1, 3, 1'b0);
    run_one(1, 1, 0, 2, 1'b0);

    reset_mid_run();
    run_one(6, 2, 99, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int n, k, r;
      n = $urandom_range(1, 12);
      r = $urandom_range(0, 9);
      if (r == 0)      k = 0;
      else if (r == 1) k = n + 1;
      else             k = $urandom_range(1, n);
      run_one(n, k, $urandom_range(0, n), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv1d_ctrl_fsm.md
# conv1d_ctrl_fsm

Sequencer for the conv1d accelerator datapath. It sits between the control-register wrapper and the MAC/memory datapath. It turns the software `start` bit into one convolution run, walks the output and kernel indices, and drives the MAC clear/enable and result-write handshake. It reports `running` and `done` back to the status register as value + write-enable pairs.

## Interface

Parameters:
- `LEN_W`, 16: width of the length and index fields.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `start_i`  in  1  control register `q` (a level). A run launches on its rising edge.
- `in_len_i`  in  LEN_W  input-vector length N. Sampled at launch.
- `k_len_i`  in  LEN_W  kernel length K. Sampled at launch.
- `mac_clr_o`  out  1  clear the accumulator.
- `mac_en_o`  out  1  accumulate `in[in_idx_o] * k[k_idx_o]` this cycle.
- `in_idx_o`  out  LEN_W  input-sample address.
- `k_idx_o`  out  LEN_W  kernel-tap address.
- `out_idx_o`  out  LEN_W  current output-sample index.
- `out_valid_o`  out  1  accumulator result valid for `out_idx_o`.
- `out_ready_i`  in  1  result sink accepts the result.
- `running_o`, `running_e_o`  out  1 each  status.running data and write strobe.
- `done_o`, `done_e_o`  out  1 each  status.done data and write strobe.
- `err_o`  out  1  the last launch had illegal lengths. Sticky until the next launch.

## Operation

- Edge detect: `start_q` is a registered copy of `start_i`. Launch = `start_i & ~start_q`, and it is honoured only in IDLE. An edge in any other state is dropped.
- Output length M = N − K + 1 (valid convolution). The lengths are legal iff 1 ≤ K ≤ N. All arithmetic is unsigned LEN_W, and `in_idx = out_idx + k` never exceeds N−1.
- States:
  - IDLE:
    - On launch with legal lengths: latch N, K, M; clear `out_idx` and `err_o`; pulse `running_e_o` with `running_o=1` and `done_e_o` with `done_o=0`; go to CLEAR.
    - On launch with illegal lengths: set `err_o`; go to FINISH. No MAC activity occurs.
  - CLEAR: `mac_clr_o=1` for one cycle; `k`←0; go to MAC.
  - MAC: `mac_en_o=1` with `k_idx_o=k` and `in_idx_o=out_idx+k`; `k`++. When `k==K−1`, go to WRITE.
  - WRITE:
    - `out_valid_o=1` and it is held until `out_ready_i`. `out_idx_o` is stable while waiting.
    - On the handshake: if `out_idx==M−1`, go to FINISH; otherwise `out_idx`++ and go to CLEAR.
  - FINISH: one cycle; pulse `running_e_o` with `running_o=0` and `done_e_o` with `done_o=1`; go to IDLE.
- Outside the state that drives them, `mac_clr_o`, `mac_en_o` and `out_valid_o` are 0.
- Index outputs:
  - `in_idx_o` and `k_idx_o` are 0 outside MAC.
  - `out_idx_o` holds its last value until the next launch.

## Timing

- Reset values:
  - all outputs 0;
  - state IDLE;
  - counters 0;
  - `start_q`=1, so a `start_i` held high through reset does not launch a run.
- Reset mid-run: the block returns to IDLE on the next edge. No `done` pulse and no `out_valid_o` occur afterwards.
- Launch latency: `start_i` rises in cycle T; the strobes assert in T (combinational from IDLE); `mac_clr_o` asserts in T+1.
- Per output, with `out_ready_i` held high: 1 CLEAR + K MAC + 1 WRITE = K+2 cycles.
- Whole run: M·(K+2) + 1 cycles from CLEAR entry to the FINISH cycle inclusive.
- Back-pressure: each cycle `out_ready_i` is low adds exactly one cycle.
- K=1: MAC lasts a single cycle. N=K: M=1.
- Each strobe (`running_e_o`, `done_e_o`) is exactly one cycle wide per event.
- A new launch is accepted in IDLE as early as the cycle after FINISH, provided `start_i` shows a fresh rising edge.

## Structure

- Package `conv1d_ctrl_pkg` holds:
  - `conv1d_ctrl_state_e` with values IDLE, CLEAR, MAC, WRITE, FINISH;
  - the default `LEN_W`.
- Single module with no sub-modules: the FSM plus the `k` and `out_idx` counters and the length latches.
- The status outputs connect directly to the `done`/`done_e`/`running`/`running_e` inputs of the control-register wrapper. `start_i` connects to its `start` output.

## Test plan

- N=8, K=3, `out_ready_i`=1, one start edge:
  - 6 `out_valid_o` pulses with `out_idx_o` 0..5;
  - MAC cycles for output 2 show `in_idx_o` 2,3,4 against `k_idx_o` 0,1,2;
  - FINISH occurs 30 cycles after the first `mac_clr_o`;
  - `done_o=1` and `running_o=0` are strobed once.
- N=4, K=4: exactly 1 output, 4 `mac_en_o` cycles, then done. N=5, K=1: 5 outputs, each with a single MAC cycle.
- K=0, and separately K=6 with N=5: `err_o`=1, no `mac_en_o`, done strobed in the cycle after launch, `running_o` strobed high then low.
- Back-pressure with N=6, K=2, `out_ready_i` low for 3 cycles on output 1: `out_valid_o` and `out_idx_o=1` are held; the total run grows by 3 cycles.
- `start_i` toggled mid-run, and `start_i` held high across reset: no extra run launches.
- `rst_i` asserted during MAC of output 3: all outputs are 0 the next cycle; no `done_e_o` or `out_valid_o` follows; a subsequent start edge runs cleanly.
